hilo_sched: RTL and testbench
=============================

# hilo_sched

Sequencing controller for the multi-cycle multiply/divide resources in the execute-stage ALU, and owner of the architectural HI/LO registers. Takes one HI/LO-class instruction per EX slot: MULT/MULTU/DIV/DIVU/MTHI/MTLO. It pulses the multiplier or divider start, holds the sign controls, and stalls the pipeline until the ALU reports completion. It then commits the 64-bit result to HI/LO and recovers cleanly from an exception flush while a unit is still running.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  EX holds a valid instruction this cycle.
- op_code  in  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other values = not a HI/LO op.
- op_wdata  in  32  rs value for MTHI/MTLO.
- flush  in  1  exception/cancel of the EX instruction; highest priority.
- opreat_over  in  1  ALU combined idle/done flag; low while multiplier or divider is busy.
- mult_result  in  64  {HI,LO} product from the ALU.
- diver_result  in  64  {remainder,quotient} from the ALU, sign-corrected.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_sign  out  1  1 = signed multiply.
- diver_start  out  1  one-cycle start pulse to the divider.
- div_sign  out  1  1 = signed divide.
- stall_req  out  1  hold IF/ID/EX; operands on the ALU stay stable while high.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

## Operation
- States: IDLE, START, WAIT, WRITE, DRAIN. Internal registers: op_kind (mult or div), sign bit, and a 1-bit wait_first flag.
- **IDLE**
  - op_valid & MULT/MULTU/DIV/DIVU & !flush: capture kind and sign (MULT/DIV signed), assert stall_req, go to START.
  - op_valid & MTHI & !flush: hi <= op_wdata at the edge. MTLO does the same for lo. No stall; stay in IDLE.
- **START**
  - Assert exactly one of mult_start/diver_start for this single cycle, plus stall_req.
  - Set wait_first, go to WAIT.
- **WAIT**
  - stall_req high. opreat_over is ignored in the first WAIT cycle (wait_first=1) because the unit has not yet dropped it.
  - From the second cycle on, opreat_over=1 moves to WRITE.
- **WRITE**
  - stall_req low, so the instruction leaves EX at the end of this cycle.
  - At the edge: mult gives {hi,lo} <= mult_result; div gives hi <= diver_result[63:32], lo <= diver_result[31:0].
  - op_valid is ignored in WRITE. Go to IDLE.
- mult_sign/div_sign are registered and held from START through WRITE inclusive, because the ALU's divide sign correction depends on them at WRITE. They return to 0 in IDLE.
- **flush**
  - In START or WAIT: go to DRAIN, no start pulse that cycle, no HI/LO write.
  - In WRITE: suppress the write, go to IDLE.
  - In IDLE: suppress any MTHI/MTLO write and do not leave IDLE.
- **DRAIN**: the abandoned unit is still running. Stay until opreat_over=1, sampled no earlier than the second DRAIN cycle, then go to IDLE.
  - stall_req in DRAIN = op_valid & (op_code in 001..110).
  - A new instruction is therefore held, not lost.
- Divide by zero: no exception. Whatever the divider returns is committed.

## Timing
- Reset (asynchronous, immediate): state IDLE, hi=0, lo=0, mult_start=0, diver_start=0, mult_sign=0, div_sign=0, stall_req=0.
- stall_req is combinational from state, op_valid and op_code. All other outputs are registered.
- Mult/div issued in cycle 0 (IDLE): START in cycle 1, WAIT from cycle 2.
  - If opreat_over is first sampled high in cycle k (k≥3), WRITE is cycle k+1 and hi/lo are visible in cycle k+2.
  - stall_req is high in cycles 0..k. Minimum occupancy is 4 cycles.
- A back-to-back HI/LO op arriving in the cycle after WRITE is accepted in IDLE with no bubble.
- MTHI/MTLO: 1 cycle, result visible on hi/lo the next cycle.
- A reset mid-operation abandons everything. The ALU units are reset by the same rst.

## Test plan
- Reset mid-WAIT with hi=lo=0x1234_5678 preloaded → immediately hi=lo=0, state IDLE, stall_req=0 (with op_valid low).
- MULT A=0xFFFF_FFFE (−2), B=3 → mult_start pulses once in cycle 1 with mult_sign=1; after opreat_over rises, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; stall_req drops exactly in WRITE.
- DIVU A=7, B=2 then DIV A=−7, B=2 back-to-back → first gives lo=3, hi=1; second gives lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; div_sign held high through WRITE; no idle bubble between them.
- MTHI 0xDEAD_BEEF then MTLO 0x0000_0042 on consecutive cycles → hi/lo update one cycle after each; stall_req never asserts.
- DIV started, flush in the third WAIT cycle while opreat_over=0, new MULT presented next → no HI/LO write; DRAIN holds stall_req until opreat_over=1; the MULT then starts and commits correctly.
- flush with MTLO 0x5 in IDLE; flush asserted in the WRITE cycle of a MULTU → lo unchanged in both cases.

Source files
------------

// File: rtl/hilo_sched.sv
// HI/LO owner and sequencer for the multi-cycle multiplier/divider in EX.
// Issues start pulses, holds sign controls, stalls until done, commits {hi,lo}.
module hilo_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  input  logic        opreat_over,
  input  logic [63:0] mult_result,
  input  logic [63:0] diver_result,
  output logic        mult_start,
  output logic        mult_sign,
  output logic        diver_start,
  output logic        div_sign,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_WRITE, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_kind_div;
  logic        r_signed;
  logic        r_wait_first;
  logic        r_mult_start;
  logic        r_diver_start;
  logic        r_mult_sign;
  logic        r_div_sign;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic w_is_md;
  logic w_is_hl;
  logic w_accept;
  logic w_op_div;
  logic w_op_signed;
  logic w_kind_n;
  logic w_sign_n;
  logic w_busy_n;
  logic w_unit_done;

  assign w_is_md     = op_valid && (op_code >= OP_MULT) && (op_code <= OP_DIVU);
  assign w_is_hl     = op_valid && (op_code >= OP_MULT) && (op_code <= OP_MTLO);
  assign w_accept    = (r_state == S_IDLE) && w_is_md && !flush;
  assign w_op_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign w_op_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
  assign w_kind_n    = w_accept ? w_op_div : r_kind_div;
  assign w_sign_n    = w_accept ? w_op_signed : r_signed;
  assign w_busy_n    = (w_next == S_START) || (w_next == S_WAIT) || (w_next == S_WRITE);
  // The unit still shows idle in the first WAIT/DRAIN cycle, so that sample is ignored.
  assign w_unit_done = !r_wait_first && opreat_over;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_wait_first <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: w_next = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)            w_next = S_DRAIN;
        else if (w_unit_done) w_next = S_WRITE;
      end
      S_WRITE: w_next = S_IDLE;
      S_DRAIN: if (w_unit_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    case (r_state)
      S_IDLE:  stall_req = w_accept;
      S_START: stall_req = 1'b1;
      S_WAIT:  stall_req = 1'b1;
      S_WRITE: stall_req = 1'b0;
      S_DRAIN: stall_req = w_is_hl;
      default: stall_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind_div    <= 1'b0;
      r_signed      <= 1'b0;
      r_mult_start  <= 1'b0;
      r_diver_start <= 1'b0;
      r_mult_sign   <= 1'b0;
      r_div_sign    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_kind_div <= w_op_div;
        r_signed   <= w_op_signed;
      end
      r_mult_start  <= w_accept && !w_op_div;
      r_diver_start <= w_accept && w_op_div;
      r_mult_sign   <= w_busy_n && !w_kind_n && w_sign_n;
      r_div_sign    <= w_busy_n && w_kind_n && w_sign_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == S_WRITE) begin
      if (!flush) {r_hi, r_lo} <= r_kind_div ? diver_result : mult_result;
    end else if (r_state == S_IDLE && op_valid && !flush) begin
      if (op_code == OP_MTHI) r_hi <= op_wdata;
      if (op_code == OP_MTLO) r_lo <= op_wdata;
    end
  end

  // A flush landing on the START cycle cancels the pulse before the unit sees it.
  assign mult_start  = r_mult_start && !flush;
  assign diver_start = r_diver_start && !flush;
  assign mult_sign   = r_mult_sign;
  assign div_sign    = r_div_sign;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_hilo_sched.sv
// Bench for hilo_sched: a behavioural multiplier/divider drives the ALU side,
// a vector table plus hand-built flush/reset sequences drive the EX side.
module tb_hilo_sched;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_wdata;
  logic        flush;
  logic        opreat_over;
  logic [63:0] mult_result;
  logic [63:0] diver_result;
  logic        mult_start;
  logic        mult_sign;
  logic        diver_start;
  logic        div_sign;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_sched dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_wdata(op_wdata), .flush(flush), .opreat_over(opreat_over),
    .mult_result(mult_result), .diver_result(diver_result),
    .mult_start(mult_start), .mult_sign(mult_sign),
    .diver_start(diver_start), .div_sign(div_sign),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU busy model: the done flag only drops one cycle after the start pulse.
  int   lat;
  int   cnt;
  logic start_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b0;
      cnt     <= 0;
    end else begin
      start_d <= mult_start | diver_start;
      if (start_d)     cnt <= lat;
      else if (cnt != 0) cnt <= cnt - 1;
    end
  end
  assign opreat_over = (cnt == 0);

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        fw;
    int          stall;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ms;
    logic        ds;
  } vec_t;

  vec_t        vt[10];
  logic [63:0] sb[$];
  int          n_chk;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int ia, ib;
    logic sgn;
    sgn = (c == 3'd1) || (c == 3'd3);
    pa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    pb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    mult_result = 64'(pa * pb);
    ia = $signed(a);
    ib = $signed(b);
    if (b == 32'd0)  diver_result = {a, 32'hFFFF_FFFF};
    else if (sgn)    diver_result = {32'(ia % ib), 32'(ia / ib)};
    else             diver_result = {a % b, a / b};
  endtask

  task automatic run_mt(input vec_t v);
    op_valid = 1'b1;
    op_code  = v.code;
    op_wdata = v.a;
    flush    = v.fw;
    sb.push_back({v.eh, v.el});
    @(negedge clk);
    check("mt_stall", 64'(stall_req), 64'd0);
    check("mt_signs_idle", 64'({mult_sign, div_sign}), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush    = 1'b0;
    check("mt_hilo", {hi, lo}, sb.pop_front());
  endtask

  task automatic run_md(input vec_t v);
    logic [63:0] snap;
    int stalls, ms, ds;
    bit done;
    op_valid = 1'b1;
    op_code  = v.code;
    set_alu(v.code, v.a, v.b);
    sb.push_back({v.eh, v.el});
    snap = {hi, lo};
    stalls = 0; ms = 0; ds = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mult_start)  begin ms++; check("mult_sign_at_start", 64'(mult_sign), 64'(v.ms)); end
      if (diver_start) begin ds++; check("div_sign_at_start", 64'(div_sign), 64'(v.ds)); end
      if (stall_req) begin
        stalls++;
        check("hilo_hold", {hi, lo}, snap);
      end else begin
        done = 1;
        check("mult_sign_at_write", 64'(mult_sign), 64'(v.ms));
        check("div_sign_at_write", 64'(div_sign), 64'(v.ds));
        if (v.fw) flush = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("write_timeout", 64'd0, 64'd1);
    flush    = 1'b0;
    op_valid = 1'b0;
    check("mult_start_count", 64'(ms), (v.code <= 3'd2) ? 64'd1 : 64'd0);
    check("diver_start_count", 64'(ds), (v.code >= 3'd3) ? 64'd1 : 64'd0);
    if (v.stall >= 0) check("stall_cycles", 64'(stalls), 64'(v.stall));
    check("hilo_commit", {hi, lo}, sb.pop_front());
  endtask

  initial begin
    vec_t dv;
    logic [63:0] snap;
    int ds;
    n_chk = 0; n_fail = 0; lat = 2;
    vt[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         1'b0, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0};
    vt[1] = '{3'd4, 32'd7,         32'd2,         1'b0, 6, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0};
    vt[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1};
    vt[3] = '{3'd5, 32'hDEAD_BEEF, 32'd0,         1'b0, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFD, 1'b0, 1'b0};
    vt[4] = '{3'd6, 32'h0000_0042, 32'd0,         1'b0, 0, 32'hDEAD_BEEF, 32'h0000_0042, 1'b0, 1'b0};
    vt[5] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, 6, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[6] = '{3'd6, 32'h0000_0005, 32'd0,         1'b1, 0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[7] = '{3'd2, 32'd3,         32'd4,         1'b1, 6, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[8] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 6, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
    vt[9] = '{3'd3, 32'h0000_0010, 32'd0,         1'b0, 6, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b1};

    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_wdata = 32'd0; flush = 1'b0;
    mult_result = 64'd0; diver_result = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_ctrl", 64'({mult_start, diver_start, mult_sign, div_sign, stall_req}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Preload, then reset asynchronously in the middle of a WAIT.
    dv = '{3'd5, 32'h1234_5678, 32'd0, 1'b0, 0, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
    run_mt(dv);
    dv = '{3'd6, 32'h1234_5678, 32'd0, 1'b0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
    run_mt(dv);
    op_valid = 1'b1; op_code = 3'd1; set_alu(3'd1, 32'd9, 32'd9);
    repeat (3) @(posedge clk);
    #2;
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midwait_reset_hilo", {hi, lo}, 64'd0);
    check("midwait_reset_stall", 64'(stall_req), 64'd0);
    check("midwait_reset_signs", 64'({mult_sign, div_sign}), 64'd0);
    #2; rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].code == 3'd5 || vt[i].code == 3'd6) run_mt(vt[i]);
      else run_md(vt[i]);
    end

    // DIV flushed in its third WAIT cycle, MULT waiting behind the drain.
    lat = 6;
    snap = {hi, lo};
    ds = 0;
    op_valid = 1'b1; op_code = 3'd3; set_alu(3'd3, 32'd100, 32'd7);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        check("flush_while_busy", 64'(opreat_over), 64'd0);
        flush = 1'b1;
      end
      @(negedge clk);
      if (diver_start) ds++;
      check("flushed_div_hold", {hi, lo}, snap);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("flushed_div_start_count", 64'(ds), 64'd1);
    dv = '{3'd1, 32'd5, 32'hFFFF_FFFD, 1'b0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0};
    run_md(dv);
    lat = 2;

    // Back-to-back after the drained case, to confirm the FSM is clean again.
    dv = '{3'd4, 32'd100, 32'd7, 1'b0, 6, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0};
    run_md(dv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
